// File: rtl/fwd_sel_if.sv
// Bundle between the ID stage / hazard logic and the EX-stage forwarding select control.
// Valid/ready note: there is no backpressure here; an ID instruction is accepted on a clock edge exactly when id_valid=1, stall=0 and flush=0.
interface fwd_sel_if #(
  parameter int NREG_BITS = 5
);
  logic                 stall;
  logic                 flush;
  logic                 id_valid;
  logic [NREG_BITS-1:0] id_rs;
  logic [NREG_BITS-1:0] id_rt;
  logic [NREG_BITS-1:0] id_rd;
  logic                 id_regwrite;
  logic                 id_memread;
  logic [1:0]           sel_a;
  logic [1:0]           sel_b;
  logic                 load_use;

  modport master (
    output stall, flush, id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread,
    input  sel_a, sel_b, load_use
  );

  modport slave (
    input  stall, flush, id_valid, id_rs, id_rt, id_rd, id_regwrite, id_memread,
    output sel_a, sel_b, load_use
  );
endinterface

// File: rtl/fwd_sel_ctrl.sv
// EX-stage operand forwarding select generator with load-use hazard detection.
// Tracks the destination registers of the instructions in EX and MEM; selects are registered.
module fwd_sel_ctrl #(
  parameter int NREG_BITS = 5,
  parameter int FWD_EN    = 1
) (
  input logic        clk,
  input logic        reset,
  fwd_sel_if.slave   bus
);

  localparam logic FWD_ON = (FWD_EN != 0);

  logic [NREG_BITS-1:0] ex_rd_q,  ex_rd_d;
  logic                 ex_we_q,  ex_we_d;
  logic                 ex_ld_q,  ex_ld_d;
  logic [NREG_BITS-1:0] mem_rd_q, mem_rd_d;
  logic                 mem_we_q, mem_we_d;
  logic [1:0]           sel_a_q,  sel_a_d;
  logic [1:0]           sel_b_q,  sel_b_d;
  logic                 advance;

  // Newest producer (EX) wins over MEM; $0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [NREG_BITS-1:0] src,
    input logic                 ex_we,
    input logic [NREG_BITS-1:0] ex_rd,
    input logic                 mem_we,
    input logic [NREG_BITS-1:0] mem_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (src != '0) begin
      if (ex_we && (ex_rd == src))
        sel = 2'b10;
      else if (mem_we && (mem_rd == src))
        sel = 2'b01;
    end
    return sel;
  endfunction

  always_comb begin
    advance  = bus.id_valid && !bus.stall && !bus.flush;
    ex_rd_d  = '0;
    ex_we_d  = 1'b0;
    ex_ld_d  = 1'b0;
    sel_a_d  = 2'b00;
    sel_b_d  = 2'b00;
    // MEM always takes whatever was in EX, including a bubble.
    mem_rd_d = ex_rd_q;
    mem_we_d = ex_we_q;
    if (advance) begin
      ex_rd_d = bus.id_rd;
      ex_we_d = bus.id_regwrite;
      ex_ld_d = bus.id_memread;
      if (FWD_ON) begin
        sel_a_d = fwd_sel(bus.id_rs, ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
        sel_b_d = fwd_sel(bus.id_rt, ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_rd_q  <= '0;
      ex_we_q  <= 1'b0;
      ex_ld_q  <= 1'b0;
      mem_rd_q <= '0;
      mem_we_q <= 1'b0;
      sel_a_q  <= 2'b00;
      sel_b_q  <= 2'b00;
    end else begin
      ex_rd_q  <= ex_rd_d;
      ex_we_q  <= ex_we_d;
      ex_ld_q  <= ex_ld_d;
      mem_rd_q <= mem_rd_d;
      mem_we_q <= mem_we_d;
      sel_a_q  <= sel_a_d;
      sel_b_q  <= sel_b_d;
    end
  end

  assign bus.sel_a    = sel_a_q;
  assign bus.sel_b    = sel_b_q;
  // Load in EX cannot forward its data in time; external hazard logic stalls on this.
  assign bus.load_use = ex_ld_q && ex_we_q && (ex_rd_q != '0) && bus.id_valid &&
                        ((ex_rd_q == bus.id_rs) || (ex_rd_q == bus.id_rt));

endmodule

// File: tb/tb_fwd_sel_ctrl.sv
// Directed bench for fwd_sel_ctrl: hand-computed selects and load-use flags per pipeline step.
module tb_fwd_sel_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;

  fwd_sel_if #(.NREG_BITS(5)) bus ();
  fwd_sel_if #(.NREG_BITS(5)) bus_nf ();

  fwd_sel_ctrl #(.NREG_BITS(5), .FWD_EN(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Same stimulus into a forwarding-disabled copy.
  fwd_sel_ctrl #(.NREG_BITS(5), .FWD_EN(0)) dut_nf (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_nf.slave)
  );

  assign bus_nf.stall       = bus.stall;
  assign bus_nf.flush       = bus.flush;
  assign bus_nf.id_valid    = bus.id_valid;
  assign bus_nf.id_rs       = bus.id_rs;
  assign bus_nf.id_rt       = bus.id_rt;
  assign bus_nf.id_rd       = bus.id_rd;
  assign bus_nf.id_regwrite = bus.id_regwrite;
  assign bus_nf.id_memread  = bus.id_memread;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // ---------------- drivers ----------------
  // Called just after a falling edge; settles inputs before the next rising edge.
  task automatic drive(input logic v, input int rs, input int rt, input int rd,
                       input logic we, input logic ld, input logic st, input logic fl);
    bus.id_valid    = v;
    bus.id_rs       = rs[4:0];
    bus.id_rt       = rt[4:0];
    bus.id_rd       = rd[4:0];
    bus.id_regwrite = we;
    bus.id_memread  = ld;
    bus.stall       = st;
    bus.flush       = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic nop();
    drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_sel(input string tag, input logic [1:0] ea, input logic [1:0] eb);
    check({tag, "_sel_a"}, {30'd0, bus.sel_a}, {30'd0, ea});
    check({tag, "_sel_b"}, {30'd0, bus.sel_b}, {30'd0, eb});
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b1;
    nop();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_sel("reset", 2'b00, 2'b00);
    check("reset_load_use", {31'd0, bus.load_use}, 32'd0);

    // 1: add r3,r1,r2 ; add r4,r3,r5 -> EX forward on A
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 3, 5, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t1", 2'b10, 2'b00);
    check("t1_nofwd_sel_a", {30'd0, bus_nf.sel_a}, 32'd0);

    // 2: add r3 ; nop ; sub r6,r1,r3 -> MEM forward on B
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    nop(); tick();
    check_sel("t2_nop", 2'b00, 2'b00);
    drive(1'b1, 1, 3, 6, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t2", 2'b00, 2'b01);

    // 3: r3 produced in both EX and MEM -> EX wins on both operands
    drive(1'b1, 1, 2, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 7, 8, 3, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t3_nodep", 2'b00, 2'b00);
    drive(1'b1, 3, 3, 9, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t3", 2'b10, 2'b10);

    // 4: writes to r0 are never forwarded, from EX nor from MEM
    drive(1'b1, 1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t4_ex", 2'b00, 2'b00);
    drive(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t4_mem", 2'b00, 2'b00);

    // 5: lw r2 ; add r4,r2,r1 -> load-use, one stall bubble, then MEM forward
    drive(1'b1, 1, 0, 2, 1'b1, 1'b1, 1'b0, 1'b0);
    check("t5_lw_in_id", {31'd0, bus.load_use}, 32'd0);
    tick();
    drive(1'b1, 2, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_load_use", {31'd0, bus.load_use}, 32'd1);
    check("t5_nofwd_load_use", {31'd0, bus_nf.load_use}, 32'd1);
    drive(1'b1, 2, 1, 4, 1'b1, 1'b0, 1'b1, 1'b0); tick();
    check_sel("t5_bubble", 2'b00, 2'b00);
    drive(1'b1, 2, 1, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_after_stall_lu", {31'd0, bus.load_use}, 32'd0);
    tick();
    check_sel("t5", 2'b01, 2'b00);

    // flush with stall: one bubble; the producer still reaches MEM
    drive(1'b1, 1, 2, 7, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 7, 1, 8, 1'b1, 1'b0, 1'b1, 1'b1); tick();
    check_sel("flush_bubble", 2'b00, 2'b00);
    drive(1'b1, 7, 1, 8, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("flush_after", 2'b01, 2'b00);

    // load_use boundaries: load to r0, and id_valid low
    drive(1'b1, 1, 2, 0, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b1, 0, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_r0", {31'd0, bus.load_use}, 32'd0);
    drive(1'b1, 1, 2, 9, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    drive(1'b0, 9, 9, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_invalid", {31'd0, bus.load_use}, 32'd0);
    drive(1'b1, 5, 9, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    check("lu_rt", {31'd0, bus.load_use}, 32'd1);
    nop(); tick();

    // 6: reset while two writers are in flight
    drive(1'b1, 1, 2, 10, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    drive(1'b1, 10, 2, 11, 1'b1, 1'b1, 1'b0, 1'b0); tick();
    check_sel("t6_pre", 2'b10, 2'b00);
    drive(1'b1, 11, 10, 13, 1'b1, 1'b0, 1'b0, 1'b0);
    check("t6_pre_load_use", {31'd0, bus.load_use}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check_sel("t6_reset", 2'b00, 2'b00);
    check("t6_reset_load_use", {31'd0, bus.load_use}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 11, 10, 13, 1'b1, 1'b0, 1'b0, 1'b0); tick();
    check_sel("t6_after", 2'b00, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Safety net against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
